mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 tb/tb_mult_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// A two-state controller runs a countdown for the programmed latency. The
// result is written to HI/LO on the same edge that Busy falls.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 busy_nxt;
    logic [WIDTH-1:0]     hi_nxt, lo_nxt;
    logic                 load;

    // Operands captured at the accepting edge
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;

    // Datapath: evaluated from the latched operands only
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          b_div;
    logic                      div_zero, div_ovf;
    logic signed [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]          quo_u, rem_u;

    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                    $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    assign div_zero = (b_q == '0);
    assign div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    // Divisor forced to 1 for zero (result discarded) and for the signed
    // overflow case, where most-negative / 1 gives the required quotient and
    // a zero remainder.
    assign b_div  = (div_zero || (div_ovf && op_q == OP_DIV)) ? WIDTH'(1) : b_q;
    assign quo_s  = $signed(a_q) / $signed(b_div);
    assign rem_s  = $signed(a_q) % $signed(b_div);
    assign quo_u  = a_q / b_div;
    assign rem_u  = a_q % b_div;

    // Controller state, countdown and architectural registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Busy  <= busy_nxt;
            HI    <= hi_nxt;
            LO    <= lo_nxt;
        end
    end

    // Operand capture on an accepted multiply/divide
    always_ff @(posedge clk) begin
        if (load) begin
            op_q <= MDUOp;
            a_q  <= In1;
            b_q  <= In2;
        end
    end

    // Next-state, countdown and result selection
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = Busy;
        hi_nxt    = HI;
        lo_nxt    = LO;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (Start && reset_n) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            load      = 1'b1;
                            cnt_nxt   = CW'(MULT_CYCLES);
                            busy_nxt  = 1'b1;
                            state_nxt = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            load      = 1'b1;
                            cnt_nxt   = CW'(DIV_CYCLES);
                            busy_nxt  = 1'b1;
                            state_nxt = RUN;
                        end
                        OP_MTHI: hi_nxt = In1;
                        OP_MTLO: lo_nxt = In1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                    case (op_q)
                        OP_MULT: begin
                            hi_nxt = prod_s[2*WIDTH-1:WIDTH];
                            lo_nxt = prod_s[WIDTH-1:0];
                        end
                        OP_MULTU: begin
                            hi_nxt = prod_u[2*WIDTH-1:WIDTH];
                            lo_nxt = prod_u[WIDTH-1:0];
                        end
                        OP_DIV: begin
                            if (!div_zero) begin
                                hi_nxt = rem_s;
                                lo_nxt = quo_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                hi_nxt = rem_u;
                                lo_nxt = quo_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a default 32-bit instance plus a 16-bit
// instance with short latencies.
module tb_mult_div_unit;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                           DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start32 = 1'b0, start16 = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] in1 = '0, in2 = '0;
    logic        busy32, busy16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_div_unit dut32 (
        .clk(clk), .reset_n(reset_n), .Start(start32), .MDUOp(op),
        .In1(in1), .In2(in2), .Busy(busy32), .HI(hi32), .LO(lo32)
    );

    mult_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset_n(reset_n), .Start(start16), .MDUOp(op),
        .In1(in1[15:0]), .In2(in2[15:0]), .Busy(busy16), .HI(hi16), .LO(lo16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one multiply/divide, check HI holds during busy, latency and result
    task automatic run(input bit w16, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input string tag);
        logic [31:0] hi0;
        int n;
        hi0 = w16 ? {16'h0, hi16} : hi32;
        op = o; in1 = a; in2 = b;
        if (w16) start16 = 1'b1; else start32 = 1'b1;
        tick();
        start16 = 1'b0; start32 = 1'b0;
        in1 = 32'hA5A5A5A5; in2 = 32'h5A5A5A5A;
        chk({tag, "_hold"}, 64'(w16 ? {16'h0, hi16} : hi32), 64'(hi0));
        n = 0;
        while ((w16 ? busy16 : busy32) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_hi"}, 64'(w16 ? {16'h0, hi16} : hi32), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(w16 ? {16'h0, lo16} : lo32), 64'(exp_lo));
    endtask

    initial begin
        int n;
        // Reset
        tick(); tick();
        chk("rst_busy32", 64'(busy32), 64'(0));
        chk("rst_hi32", 64'(hi32), 64'(0));
        chk("rst_lo32", 64'(lo32), 64'(0));
        chk("rst_busy16", 64'(busy16), 64'(0));
        reset_n = 1'b1;
        tick();

        // Signed / unsigned multiply
        run(0, MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
        run(0, MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, "multu");

        // Signed / unsigned divide
        run(0, DIV,  32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        run(0, DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");

        // Moves
        op = MTHI; in1 = 32'h11; start32 = 1'b1; tick(); start32 = 1'b0;
        chk("mthi_hi", 64'(hi32), 64'h11);
        chk("mthi_busy", 64'(busy32), 64'(0));
        op = MTLO; in1 = 32'h22; start32 = 1'b1; tick(); start32 = 1'b0;
        chk("mtlo_lo", 64'(lo32), 64'h22);
        chk("mtlo_hi", 64'(hi32), 64'h11);

        // Divide by zero with a MULT request ignored mid-flight
        op = DIVU; in1 = 32'd5; in2 = 32'd0; start32 = 1'b1; tick(); start32 = 1'b0;
        n = 0;
        while (busy32 && n < 100) begin
            n++;
            if (n == 3) begin
                start32 = 1'b1; op = MULT; in1 = 32'd2; in2 = 32'd3;
            end
            tick();
            start32 = 1'b0;
        end
        chk("dz_cycles", 64'(n), 64'(10));
        chk("dz_hi", 64'(hi32), 64'h11);
        chk("dz_lo", 64'(lo32), 64'h22);
        tick();
        chk("dz_noqueue", 64'(busy32), 64'(0));

        // Undefined op changes nothing
        op = 3'b111; in1 = 32'hDEADBEEF; start32 = 1'b1; tick(); start32 = 1'b0;
        chk("undef_busy", 64'(busy32), 64'(0));
        chk("undef_hi", 64'(hi32), 64'h11);
        chk("undef_lo", 64'(lo32), 64'h22);

        // Signed overflow
        run(0, DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, "ovf");

        // Reset mid-divide with a Start on the reset edge
        op = DIV; in1 = 32'd100; in2 = 32'd7; start32 = 1'b1; tick(); start32 = 1'b0;
        tick(); tick(); tick();
        chk("rst_mid_busy_before", 64'(busy32), 64'(1));
        reset_n = 1'b0; start32 = 1'b1; op = MULT; in1 = 32'd9; in2 = 32'd9;
        tick();
        reset_n = 1'b1; start32 = 1'b0;
        chk("rst_mid_busy", 64'(busy32), 64'(0));
        chk("rst_mid_hi", 64'(hi32), 64'(0));
        chk("rst_mid_lo", 64'(lo32), 64'(0));
        tick();
        chk("rst_start_dropped", 64'(busy32), 64'(0));
        run(0, MULT, 32'd2, 32'd3, 5, 32'h0, 32'd6, "post_rst");

        // Back-to-back multiplies with no idle gap
        run(0, MULT, 32'd5, 32'd7, 5, 32'h0, 32'd35, "b2b_a");
        run(0, MULT, 32'hFFFFFFFC, 32'd6, 5, 32'hFFFFFFFF, 32'hFFFFFFE8, "b2b_b");

        // 16-bit instance, short latencies
        run(1, MULT, 32'hFFFE, 32'd3, 1, 32'hFFFF, 32'hFFFA, "w16_mult");
        run(1, MULT, 32'd300, 32'd300, 1, 32'h0001, 32'h5F90, "w16_b2b");
        run(1, DIVU, 32'd100, 32'd7, 3, 32'd2, 32'd14, "w16_divu");
        run(1, DIV, 32'h8000, 32'hFFFF, 3, 32'h0, 32'h8000, "w16_ovf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
